// File: rtl/att_pid_pkg.sv
// Shared definitions for the attitude PID stage: FSM states, axis indices,
// default widths and a generic signed saturation helper.
package pid_pkg;

  localparam int unsigned DEF_IN_W      = 24;
  localparam int unsigned DEF_OUT_W     = 16;
  localparam int unsigned DEF_GAIN_FRAC = 8;
  localparam int unsigned GAIN_W        = 16;
  localparam int unsigned MUL_B_W       = 33;
  localparam int unsigned PROD_W        = GAIN_W + 1 + MUL_B_W;
  localparam int unsigned SUM_W         = 48;
  localparam int unsigned ACC_W         = 32;

  localparam logic [1:0] AX_PITCH = 2'd0;
  localparam logic [1:0] AX_ROLL  = 2'd1;
  localparam logic [1:0] AX_YAW   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_P,
    ST_I,
    ST_D,
    ST_SUM,
    ST_DONE
  } pid_state_t;

  // Clip v into the w-bit signed range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/att_pid_if.sv
// Request/response bundle between the complementary filter, the PID stage and the mixer.
interface att_pid_if #(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned OUT_W = 16
);
  logic                    pid_start;
  logic                    pid_clr;
  logic signed [IN_W-1:0]  cur_pitch;
  logic signed [IN_W-1:0]  cur_roll;
  logic signed [IN_W-1:0]  cur_yaw;
  logic signed [IN_W-1:0]  tgt_pitch;
  logic signed [IN_W-1:0]  tgt_roll;
  logic signed [IN_W-1:0]  tgt_yaw;
  logic                    busy;
  logic                    pid_done;
  logic signed [OUT_W-1:0] out_pitch;
  logic signed [OUT_W-1:0] out_roll;
  logic signed [OUT_W-1:0] out_yaw;

  modport master (
    output pid_start, pid_clr,
    output cur_pitch, cur_roll, cur_yaw, tgt_pitch, tgt_roll, tgt_yaw,
    input  busy, pid_done, out_pitch, out_roll, out_yaw
  );

  modport slave (
    input  pid_start, pid_clr,
    input  cur_pitch, cur_roll, cur_yaw, tgt_pitch, tgt_roll, tgt_yaw,
    output busy, pid_done, out_pitch, out_roll, out_yaw
  );
endinterface

// File: rtl/att_pid_sat.sv
// Combinational signed clip from IN_W to OUT_W bits.
module sat_signed import pid_pkg::*; #(
  parameter int unsigned IN_W  = 25,
  parameter int unsigned OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [63:0] din_ext;

  always_comb begin
    din_ext = 64'(din);
    dout    = OUT_W'(saturate(din_ext, OUT_W));
  end

endmodule

// File: rtl/att_pid.sv
// Three-axis attitude PID: pitch, roll, yaw processed in turn through one
// registered multiplier; saturated corrections presented together on pid_done.
module att_pid import pid_pkg::*; #(
  parameter int unsigned       IN_W      = DEF_IN_W,
  parameter int unsigned       OUT_W     = DEF_OUT_W,
  parameter int unsigned       GAIN_FRAC = DEF_GAIN_FRAC,
  parameter logic [GAIN_W-1:0] KP        = 16'd256,
  parameter logic [GAIN_W-1:0] KI        = 16'd0,
  parameter logic [GAIN_W-1:0] KD        = 16'd0,
  parameter int unsigned       INT_LIM   = 2**20
) (
  input logic      clk,
  input logic      rst_n,
  att_pid_if.slave pif
);

  localparam logic signed [ACC_W:0] LIM_P = $signed((ACC_W + 1)'(INT_LIM));
  localparam logic signed [ACC_W:0] LIM_N = -LIM_P;

  pid_state_t               state;
  logic [1:0]               ax;
  logic                     busy_q;
  logic                     done_q;
  logic                     clr_pend;
  logic signed [IN_W-1:0]   cur_q  [3];
  logic signed [IN_W-1:0]   tgt_q  [3];
  logic signed [ACC_W-1:0]  acc_q  [3];
  logic signed [IN_W-1:0]   prev_q [3];
  logic signed [OUT_W-1:0]  hold_q [3];
  logic signed [OUT_W-1:0]  out_q  [3];
  logic signed [IN_W-1:0]   e_q;
  logic signed [PROD_W-1:0] mul_q;
  logic signed [SUM_W-1:0]  p_q;
  logic signed [SUM_W-1:0]  i_q;

  logic signed [IN_W:0]      err_raw;
  logic signed [IN_W-1:0]    err_sat;
  logic signed [ACC_W:0]     acc_sum;
  logic signed [ACC_W-1:0]   acc_new;
  logic signed [IN_W:0]      d_diff;
  logic [GAIN_W-1:0]         mul_a;
  logic signed [MUL_B_W-1:0] mul_b;
  logic signed [PROD_W-1:0]  mul_a_ext;
  logic signed [PROD_W-1:0]  mul_b_ext;
  logic signed [PROD_W-1:0]  prod;
  logic signed [SUM_W-1:0]   shr;
  logic signed [SUM_W-1:0]   sum;
  logic signed [OUT_W-1:0]   sum_sat;

  always_comb begin
    err_raw = (IN_W + 1)'(tgt_q[ax]) - (IN_W + 1)'(cur_q[ax]);
    acc_sum = (ACC_W + 1)'(acc_q[ax]) + (ACC_W + 1)'(e_q);
    if (acc_sum > LIM_P)      acc_new = ACC_W'(LIM_P);
    else if (acc_sum < LIM_N) acc_new = ACC_W'(LIM_N);
    else                      acc_new = ACC_W'(acc_sum);
    d_diff = (IN_W + 1)'(e_q) - (IN_W + 1)'(prev_q[ax]);
    mul_a  = '0;
    mul_b  = '0;
    // Operands are issued one state ahead of where the scaled product is consumed.
    case (state)
      ST_P: begin mul_a = KP; mul_b = MUL_B_W'(e_q);     end
      ST_I: begin mul_a = KI; mul_b = MUL_B_W'(acc_new); end
      ST_D: begin mul_a = KD; mul_b = MUL_B_W'(d_diff);  end
      default: ;
    endcase
    mul_a_ext = $signed({{(PROD_W - GAIN_W){1'b0}}, mul_a});
    mul_b_ext = PROD_W'(mul_b);
    prod      = mul_a_ext * mul_b_ext;
    shr       = SUM_W'(mul_q >>> GAIN_FRAC);
    sum       = p_q + i_q + shr;
  end

  sat_signed #(.IN_W(IN_W + 1), .OUT_W(IN_W)) u_sat_err (.din(err_raw), .dout(err_sat));
  sat_signed #(.IN_W(SUM_W),    .OUT_W(OUT_W)) u_sat_sum (.din(sum),     .dout(sum_sat));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ax       <= AX_PITCH;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clr_pend <= 1'b0;
      e_q      <= '0;
      mul_q    <= '0;
      p_q      <= '0;
      i_q      <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cur_q[i]  <= '0;
        tgt_q[i]  <= '0;
        acc_q[i]  <= '0;
        prev_q[i] <= '0;
        hold_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (busy_q && pif.pid_clr) clr_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pif.pid_clr) begin
            for (int unsigned i = 0; i < 3; i++) begin
              acc_q[i]  <= '0;
              prev_q[i] <= '0;
            end
          end
          if (pif.pid_start) begin
            cur_q[AX_PITCH] <= pif.cur_pitch;
            cur_q[AX_ROLL]  <= pif.cur_roll;
            cur_q[AX_YAW]   <= pif.cur_yaw;
            tgt_q[AX_PITCH] <= pif.tgt_pitch;
            tgt_q[AX_ROLL]  <= pif.tgt_roll;
            tgt_q[AX_YAW]   <= pif.tgt_yaw;
            ax              <= AX_PITCH;
            busy_q          <= 1'b1;
            state           <= ST_ERR;
          end
        end
        ST_ERR: begin
          e_q   <= err_sat;
          state <= ST_P;
        end
        ST_P: begin
          mul_q <= prod;
          state <= ST_I;
        end
        ST_I: begin
          p_q       <= shr;
          mul_q     <= prod;
          acc_q[ax] <= acc_new;
          state     <= ST_D;
        end
        ST_D: begin
          i_q        <= shr;
          mul_q      <= prod;
          prev_q[ax] <= e_q;
          state      <= ST_SUM;
        end
        ST_SUM: begin
          hold_q[ax] <= sum_sat;
          if (ax == AX_YAW) begin
            out_q[AX_PITCH] <= hold_q[AX_PITCH];
            out_q[AX_ROLL]  <= hold_q[AX_ROLL];
            out_q[AX_YAW]   <= sum_sat;
            busy_q          <= 1'b0;
            done_q          <= 1'b1;
            state           <= ST_DONE;
          end else begin
            ax    <= ax + 2'd1;
            state <= ST_ERR;
          end
        end
        ST_DONE: begin
          if (clr_pend || pif.pid_clr) begin
            for (int unsigned i = 0; i < 3; i++) begin
              acc_q[i]  <= '0;
              prev_q[i] <= '0;
            end
          end
          clr_pend <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pif.busy      = busy_q;
  assign pif.pid_done  = done_q;
  assign pif.out_pitch = out_q[AX_PITCH];
  assign pif.out_roll  = out_q[AX_ROLL];
  assign pif.out_yaw   = out_q[AX_YAW];

endmodule
